// File: rtl/ctrl_pkg.sv
// Shared types for the multi-cycle RV32I controller.
// Holds the state encoding, opcode constants, select encodings and the decode bundle.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_TARGET = 2'd1,
        PC_JALR   = 2'd2,
        PC_TRAP   = 2'd3
    } pc_src_e;

    typedef enum logic [1:0] {
        WB_DMEM = 2'd0,
        WB_ALU  = 2'd1,
        WB_PC4  = 2'd2
    } wb_sel_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_type_e;

    typedef enum logic [2:0] {
        CL_LOAD   = 3'd0,
        CL_STORE  = 3'd1,
        CL_ALU    = 3'd2,
        CL_BRANCH = 3'd3,
        CL_JAL    = 3'd4,
        CL_JALR   = 3'd5
    } class_e;

    typedef struct packed {
        logic      legal;
        class_e    cls;
        logic      alu_a_sel;
        logic      alu_b_sel;
        imm_type_e imm_type;
    } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct3 decoder: legality, instruction class, ALU/imm selects.
// Ports: opcode_i, funct3_i in; dec_o bundle out (all zero for illegal encodings).
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter bit ENABLE_JUMP = 1'b1
) (
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    output dec_t       dec_o
);

    always_comb begin
        dec_o = '0;
        unique case (opcode_i)
            OP_LOAD: begin
                dec_o.legal     = 1'b1;
                dec_o.cls       = CL_LOAD;
                dec_o.alu_b_sel = 1'b1;
                dec_o.imm_type  = IMM_I;
            end
            OP_STORE: begin
                dec_o.legal     = 1'b1;
                dec_o.cls       = CL_STORE;
                dec_o.alu_b_sel = 1'b1;
                dec_o.imm_type  = IMM_S;
            end
            OP_OP: begin
                dec_o.legal = 1'b1;
                dec_o.cls   = CL_ALU;
            end
            OP_OPIMM: begin
                dec_o.legal     = 1'b1;
                dec_o.cls       = CL_ALU;
                dec_o.alu_b_sel = 1'b1;
                dec_o.imm_type  = IMM_I;
            end
            OP_BRANCH: begin
                dec_o.legal    = 1'b1;
                dec_o.cls      = CL_BRANCH;
                dec_o.imm_type = IMM_B;
            end
            OP_LUI: begin
                dec_o.legal     = 1'b1;
                dec_o.cls       = CL_ALU;
                dec_o.alu_b_sel = 1'b1;
                dec_o.imm_type  = IMM_U;
            end
            OP_AUIPC: begin
                dec_o.legal     = 1'b1;
                dec_o.cls       = CL_ALU;
                dec_o.alu_a_sel = 1'b1;
                dec_o.alu_b_sel = 1'b1;
                dec_o.imm_type  = IMM_U;
            end
            OP_JAL: begin
                if (ENABLE_JUMP) begin
                    dec_o.legal     = 1'b1;
                    dec_o.cls       = CL_JAL;
                    dec_o.alu_a_sel = 1'b1;
                    dec_o.alu_b_sel = 1'b1;
                    dec_o.imm_type  = IMM_J;
                end
            end
            OP_JALR: begin
                if (ENABLE_JUMP && funct3_i == 3'b000) begin
                    dec_o.legal     = 1'b1;
                    dec_o.cls       = CL_JALR;
                    dec_o.alu_b_sel = 1'b1;
                    dec_o.imm_type  = IMM_I;
                end
            end
            default: dec_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM with req/ack memory handshakes and timeout trap.
// Ports: clk/rst_n; opcode/funct3/branch_taken/acks in; enables, selects, trap, state_o out.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter bit          ENABLE_JUMP = 1'b1,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter bit          TRAP_HALT   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       branch_taken,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       dmem_w_en,
    output logic       ir_w_en,
    output logic       reg_w_en,
    output logic       pc_w_en,
    output logic [1:0] pc_src,
    output logic [1:0] wb_sel,
    output logic       alu_a_sel,
    output logic       alu_b_sel,
    output logic [2:0] imm_type,
    output logic       trap,
    output logic [2:0] state_o
);

    localparam int unsigned CW =
        (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LIMIT = CW'(MEM_TIMEOUT);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    dec_t          dec;
    logic          waiting;
    logic          timed_out;

    ctrl_decode #(.ENABLE_JUMP(ENABLE_JUMP)) u_decode (
        .opcode_i (opcode),
        .funct3_i (funct3),
        .dec_o    (dec)
    );

    // A same-cycle ack always beats the timeout.
    always_comb begin
        waiting   = (state_q == S_FETCH && !imem_ack) ||
                    (state_q == S_MEM   && !dmem_ack);
        timed_out = waiting && (MEM_TIMEOUT != 0) && (cnt_q == TO_LIMIT);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH: begin
                if (imem_ack)       state_d = S_DECODE;
                else if (timed_out) state_d = S_TRAP;
            end
            S_DECODE: state_d = dec.legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (dec.cls == CL_LOAD || dec.cls == CL_STORE)
                    state_d = S_MEM;
                else if (dec.cls == CL_BRANCH)
                    state_d = S_FETCH;
                else
                    state_d = S_WB;
            end
            S_MEM: begin
                if (dmem_ack)
                    state_d = (dec.cls == CL_STORE) ? S_FETCH : S_WB;
                else if (timed_out)
                    state_d = S_TRAP;
            end
            S_WB:   state_d = S_FETCH;
            S_TRAP: if (!TRAP_HALT) state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase

        // Counter restarts on every state entry.
        if (state_d != state_q)
            cnt_d = '0;
        else if (waiting && MEM_TIMEOUT != 0)
            cnt_d = cnt_q + CW'(1);
        else
            cnt_d = cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are forced low while reset is held so no strobe leaks through.
    always_comb begin
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_w_en = 1'b0;
        ir_w_en   = 1'b0;
        reg_w_en  = 1'b0;
        pc_w_en   = 1'b0;
        pc_src    = PC_PLUS4;
        wb_sel    = WB_DMEM;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        imm_type  = IMM_I;
        trap      = 1'b0;
        if (rst_n) begin
            if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
                alu_a_sel = dec.alu_a_sel;
                alu_b_sel = dec.alu_b_sel;
                imm_type  = dec.imm_type;
            end
            unique case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_w_en  = imem_ack;
                end
                S_EXEC: begin
                    if (dec.cls == CL_BRANCH) begin
                        pc_w_en = 1'b1;
                        pc_src  = branch_taken ? PC_TARGET : PC_PLUS4;
                    end
                end
                S_MEM: begin
                    dmem_req  = 1'b1;
                    dmem_w_en = (dec.cls == CL_STORE);
                    pc_w_en   = dmem_ack && (dec.cls == CL_STORE);
                end
                S_WB: begin
                    reg_w_en = 1'b1;
                    pc_w_en  = 1'b1;
                    if (dec.cls == CL_JAL)       pc_src = PC_TARGET;
                    else if (dec.cls == CL_JALR) pc_src = PC_JALR;
                    if (dec.cls == CL_LOAD)
                        wb_sel = WB_DMEM;
                    else if (dec.cls == CL_JAL || dec.cls == CL_JALR)
                        wb_sel = WB_PC4;
                    else
                        wb_sel = WB_ALU;
                end
                S_TRAP: begin
                    trap = 1'b1;
                    if (!TRAP_HALT) begin
                        pc_w_en = 1'b1;
                        pc_src  = PC_TRAP;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: instruction-level reference model plus directed checks.
// Main instance: jumps on, timeout 4, trap restarts; second instance: halting trap, no timeout.
module tb_multicycle_controller;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rst2_n = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       branch_taken = 1'b0;
    logic       imem_ack = 1'b0;
    logic       dmem_ack = 1'b0;

    logic       imem_req, dmem_req, dmem_w_en, ir_w_en, reg_w_en, pc_w_en;
    logic [1:0] pc_src, wb_sel;
    logic       alu_a_sel, alu_b_sel, trap;
    logic [2:0] imm_type, state_o;

    logic       h_imem_req, h_dmem_req, h_dmem_w_en, h_ir_w_en, h_reg_w_en;
    logic       h_pc_w_en, h_alu_a_sel, h_alu_b_sel, h_trap;
    logic [1:0] h_pc_src, h_wb_sel;
    logic [2:0] h_imm_type, h_state_o;

    always #5 clk = ~clk;

    multicycle_controller #(
        .ENABLE_JUMP(1'b1), .MEM_TIMEOUT(TO), .TRAP_HALT(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .branch_taken(branch_taken), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_w_en(dmem_w_en),
        .ir_w_en(ir_w_en), .reg_w_en(reg_w_en), .pc_w_en(pc_w_en),
        .pc_src(pc_src), .wb_sel(wb_sel), .alu_a_sel(alu_a_sel),
        .alu_b_sel(alu_b_sel), .imm_type(imm_type), .trap(trap),
        .state_o(state_o)
    );

    multicycle_controller #(
        .ENABLE_JUMP(1'b0), .MEM_TIMEOUT(0), .TRAP_HALT(1'b1)
    ) u_halt (
        .clk(clk), .rst_n(rst2_n), .opcode(opcode), .funct3(funct3),
        .branch_taken(branch_taken), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(h_imem_req), .dmem_req(h_dmem_req), .dmem_w_en(h_dmem_w_en),
        .ir_w_en(h_ir_w_en), .reg_w_en(h_reg_w_en), .pc_w_en(h_pc_w_en),
        .pc_src(h_pc_src), .wb_sel(h_wb_sel), .alu_a_sel(h_alu_a_sel),
        .alu_b_sel(h_alu_b_sel), .imm_type(h_imm_type), .trap(h_trap),
        .state_o(h_state_o)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_w_en;
        logic       ir_w_en;
        logic       reg_w_en;
        logic       pc_w_en;
        logic [1:0] pc_src;
        logic [1:0] wb_sel;
        logic       a;
        logic       b;
        logic [2:0] imm;
        logic       trap;
    } obs_t;

    obs_t exp_o = '0;
    obs_t act;
    bit   chk_en = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;
    int   dreq_cnt = 0;
    int   regw_cnt = 0;

    assign act = {state_o, imem_req, dmem_req, dmem_w_en, ir_w_en, reg_w_en,
                  pc_w_en, pc_src, wb_sel, alu_a_sel, alu_b_sel, imm_type, trap};

    always @(negedge clk) begin
        if (chk_en) begin
            n_checks++;
            if (act !== exp_o) begin
                n_err++;
                $display("FAIL outputs t=%0t got=%h want=%h", $time, act, exp_o);
            end
            if (dmem_req) dreq_cnt++;
            if (reg_w_en) regw_cnt++;
        end
    end

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // kind: 0 load, 1 store, 2 alu, 3 branch, 4 jal, 5 jalr
    function automatic void dec(input logic [6:0] op, input logic [2:0] f3,
                                output bit legal, output int kind,
                                output logic a, output logic b,
                                output logic [2:0] imm);
        legal = 1'b1; kind = 2; a = 1'b0; b = 1'b0; imm = 3'd0;
        case (op)
            7'b0000011: begin kind = 0; b = 1'b1; end
            7'b0100011: begin kind = 1; b = 1'b1; imm = 3'd1; end
            7'b0110011: ;
            7'b0010011: b = 1'b1;
            7'b1100011: begin kind = 3; imm = 3'd2; end
            7'b0110111: begin b = 1'b1; imm = 3'd3; end
            7'b0010111: begin a = 1'b1; b = 1'b1; imm = 3'd3; end
            7'b1101111: begin kind = 4; a = 1'b1; b = 1'b1; imm = 3'd4; end
            7'b1100111: begin
                kind = 5; b = 1'b1;
                if (f3 != 3'b000) legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin a = 1'b0; b = 1'b0; imm = 3'd0; end
    endfunction

    function automatic obs_t base(input logic [2:0] st, input logic [6:0] op,
                                  input logic [2:0] f3);
        obs_t o; bit l; int k; logic a, b; logic [2:0] im;
        o = '0;
        o.st = st;
        dec(op, f3, l, k, a, b, im);
        if (st >= 3'd1 && st <= 3'd4) begin
            o.a = a; o.b = b; o.imm = im;
        end
        return o;
    endfunction

    task automatic step(input obs_t e);
        exp_o = e;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_in();
        imem_ack = 1'($urandom);
        dmem_ack = 1'($urandom);
        branch_taken = 1'($urandom);
    endtask

    task automatic trap_cycle(inout int ncyc);
        obs_t e;
        rand_in();
        e = base(3'd5, opcode, funct3);
        e.trap = 1'b1; e.pc_w_en = 1'b1; e.pc_src = 2'd3;
        step(e);
        ncyc++;
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                             input bit taken, input int iw, input int dw,
                             output int ncyc);
        bit legal; int kind; logic a, b; logic [2:0] imm; obs_t e; bit got;
        dec(op, f3, legal, kind, a, b, imm);
        opcode = op; funct3 = f3; ncyc = 0; got = 1'b0;
        for (int k = 0; k <= TO; k++) begin
            imem_ack = (k == iw); dmem_ack = 1'($urandom);
            branch_taken = 1'($urandom);
            e = base(3'd0, op, f3);
            e.imem_req = 1'b1; e.ir_w_en = (k == iw);
            step(e); ncyc++;
            if (k == iw) begin got = 1'b1; break; end
        end
        if (!got) begin trap_cycle(ncyc); return; end
        rand_in();
        step(base(3'd1, op, f3)); ncyc++;
        if (!legal) begin trap_cycle(ncyc); return; end
        rand_in();
        branch_taken = taken;
        e = base(3'd2, op, f3);
        if (kind == 3) begin
            e.pc_w_en = 1'b1; e.pc_src = taken ? 2'd1 : 2'd0;
        end
        step(e); ncyc++;
        if (kind == 3) return;
        if (kind <= 1) begin
            got = 1'b0;
            for (int k = 0; k <= TO; k++) begin
                dmem_ack = (k == dw); imem_ack = 1'($urandom);
                e = base(3'd3, op, f3);
                e.dmem_req = 1'b1; e.dmem_w_en = (kind == 1);
                e.pc_w_en = (k == dw) && (kind == 1);
                step(e); ncyc++;
                if (k == dw) begin got = 1'b1; break; end
            end
            if (!got) begin trap_cycle(ncyc); return; end
            if (kind == 1) return;
        end
        rand_in();
        e = base(3'd4, op, f3);
        e.reg_w_en = 1'b1; e.pc_w_en = 1'b1;
        e.pc_src = (kind == 4) ? 2'd1 : (kind == 5) ? 2'd2 : 2'd0;
        e.wb_sel = (kind == 0) ? 2'd0 : (kind >= 4) ? 2'd2 : 2'd1;
        step(e); ncyc++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    logic [6:0] pool [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                             7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                             7'b1100111};

    initial begin
        int n; obs_t e; logic [6:0] op; logic [2:0] f3; int sel;
        exp_o = '0;
        chk_en = 1'b1;
        imem_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1; imem_ack = 1'b0;
        #1;
        chk("rst_imem_req", int'(imem_req), 1);
        chk("rst_state", int'(state_o), 0);

        run_instr(7'b0110011, 3'd0, 1'b0, 0, 0, n); chk("add_lat", n, 4);
        dreq_cnt = 0; regw_cnt = 0;
        run_instr(7'b0000011, 3'd2, 1'b0, 0, 3, n); chk("lw_lat", n, 8);
        chk("lw_dreq_cycles", dreq_cnt, 4);
        chk("lw_regw", regw_cnt, 1);
        regw_cnt = 0;
        run_instr(7'b1100011, 3'd0, 1'b1, 0, 0, n); chk("beq_t_lat", n, 3);
        run_instr(7'b1100011, 3'd0, 1'b0, 0, 0, n); chk("beq_nt_lat", n, 3);
        chk("beq_regw", regw_cnt, 0);
        run_instr(7'b1111111, 3'd0, 1'b0, 0, 0, n); chk("illegal_lat", n, 3);
        run_instr(7'b0110011, 3'd0, 1'b0, 100, 0, n); chk("ifetch_to", n, 6);
        run_instr(7'b0110011, 3'd0, 1'b0, 4, 0, n); chk("ifetch_late", n, 8);
        run_instr(7'b0000011, 3'd0, 1'b0, 0, 100, n); chk("dmem_to", n, 9);
        run_instr(7'b0100011, 3'd2, 1'b0, 0, 0, n); chk("sw_lat", n, 4);
        run_instr(7'b1101111, 3'd5, 1'b0, 0, 0, n); chk("jal_lat", n, 4);
        run_instr(7'b1100111, 3'd0, 1'b0, 0, 0, n); chk("jalr_lat", n, 4);
        run_instr(7'b1100111, 3'd1, 1'b0, 0, 0, n); chk("jalr_bad", n, 3);

        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 11);
            f3 = 3'($urandom);
            if (sel < 9) op = pool[sel];
            else if (sel == 9) op = 7'b1111111;
            else op = 7'($urandom);
            if (op == 7'b1100111 && sel != 11) f3 = 3'd0;
            run_instr(op, f3, 1'($urandom), $urandom_range(0, 5),
                      $urandom_range(0, 5), n);
        end

        opcode = 7'b0100011; funct3 = 3'd2;
        imem_ack = 1'b1; dmem_ack = 1'b0;
        e = base(3'd0, opcode, funct3); e.imem_req = 1'b1; e.ir_w_en = 1'b1;
        step(e);
        imem_ack = 1'b0;
        step(base(3'd1, opcode, funct3));
        step(base(3'd2, opcode, funct3));
        e = base(3'd3, opcode, funct3); e.dmem_req = 1'b1; e.dmem_w_en = 1'b1;
        exp_o = e;
        #1;
        chk("sw_mem_w_en", int'(dmem_w_en), 1);
        #1;
        rst_n = 1'b0; exp_o = '0;
        #1;
        chk("rst_async_dreq", int'(dmem_req), 0);
        chk("rst_async_wen", int'(dmem_w_en), 0);
        chk("rst_async_state", int'(state_o), 0);
        @(posedge clk); #1;
        dmem_ack = 1'b1; imem_ack = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1; dmem_ack = 1'b0; imem_ack = 1'b0;
        run_instr(7'b0110011, 3'd0, 1'b0, 0, 0, n); chk("post_rst_add", n, 4);

        rst_n = 1'b0; exp_o = '0;
        imem_ack = 1'b0;
        @(posedge clk); #1;
        rst2_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("halt_no_to_state", int'(h_state_o), 0);
        chk("halt_no_to_req", int'(h_imem_req), 1);
        opcode = 7'b1101111; funct3 = 3'd0; imem_ack = 1'b1;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        chk("halt_decode", int'(h_state_o), 1);
        @(posedge clk); #1;
        chk("halt_jal_illegal", int'(h_trap), 1);
        imem_ack = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("halt_stays", int'(h_state_o), 5);
        chk("halt_trap", int'(h_trap), 1);
        chk("halt_no_pc", int'(h_pc_w_en), 0);
        chk("halt_no_req", int'(h_imem_req), 0);

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
